jedro_1_ifu: RTL and testbench



---
 rtl/jedro_1_ifu.sv | 194 +++++++++++++++++++
 tb/tb_jedro_1_ifu.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: issues sequential word fetches over a req/gnt/rvalid bus,
// buffers returned words in a prefetch FIFO and hands the FIFO head to the decoder.
// A jump flushes the FIFO, discards in-flight responses and refetches from the target.
// Optional: define JEDRO_1_IFU_PC_OUT_EN to add instr_pc_o (byte address of the head word).
module jedro_1_ifu #(
    parameter int unsigned                DATA_WIDTH      = 32,
    parameter int unsigned                IMEM_ADDR_WIDTH = 32,
    parameter logic [IMEM_ADDR_WIDTH-1:0] BOOT_ADDR       = '0,
    parameter int unsigned                FIFO_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    output logic [DATA_WIDTH-1:0]      instr_rdata_o,
`ifdef JEDRO_1_IFU_PC_OUT_EN
    output logic [IMEM_ADDR_WIDTH-1:0] instr_pc_o,
`endif
    output logic                       instr_next_avail_o,
    input  logic                       instr_next_en_i,
    input  logic                       jmp_instr_i,
    input  logic [IMEM_ADDR_WIDTH-1:0] jmp_address_i,
    output logic                       imem_req_o,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      imem_rdata_i
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthSum = FIFO_DEPTH[CntW:0];

    typedef enum logic [1:0] {StIdle, StReq, StRedirect} state_e;

    state_e                     state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IMEM_ADDR_WIDTH-1:0] target_q, target_d;
    logic [IMEM_ADDR_WIDTH-1:0] jmp_target;
    logic [CntW-1:0]            outst_q, outst_d;
    logic [CntW-1:0]            discard_q, discard_d;
    logic [CntW-1:0]            count_q, count_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]      data_mem_q [FIFO_DEPTH];
    logic                       credit_ok;
    logic                       gnt_hs;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       unused_jmp_lsb;

    assign jmp_target     = {jmp_address_i[IMEM_ADDR_WIDTH-1:2], 2'b00};
    assign unused_jmp_lsb = ^jmp_address_i[1:0];

    // Buffered words plus words still in flight must never exceed the FIFO size.
    assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DepthSum;

    assign instr_next_avail_o = (count_q != '0);
    assign instr_rdata_o      = data_mem_q[rd_ptr_q];
    assign imem_addr_o        = addr_q;

    // Request generation: REDIRECT keeps the already-presented request alive until granted.
    always_comb begin
        imem_req_o = 1'b0;
        unique case (state_q)
            StReq:      imem_req_o = credit_ok;
            StRedirect: imem_req_o = 1'b1;
            default:    imem_req_o = 1'b0;
        endcase
    end

    // Fetch FSM next state, fetch address and pending jump target.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (jmp_instr_i) addr_d = jmp_target;
            end
            StReq: begin
                if (gnt_hs) addr_d = addr_q + IMEM_ADDR_WIDTH'(4);
                if (jmp_instr_i) begin
                    // An ungranted request must stay stable, so park the target.
                    if (imem_req_o && !imem_gnt_i) begin
                        state_d  = StRedirect;
                        target_d = jmp_target;
                    end else begin
                        addr_d = jmp_target;
                    end
                end
            end
            StRedirect: begin
                if (jmp_instr_i) target_d = jmp_target;
                if (imem_gnt_i) begin
                    addr_d  = jmp_instr_i ? jmp_target : target_q;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding/discard accounting and FIFO pointer/occupancy update.
    always_comb begin
        gnt_hs = imem_req_o & imem_gnt_i;
        flush  = jmp_instr_i;
        push   = imem_rvalid_i && (discard_q == '0) && !flush;
        pop    = instr_next_avail_o && instr_next_en_i && !flush;

        outst_d = outst_q;
        if (gnt_hs)        outst_d = outst_d + CntW'(1);
        if (imem_rvalid_i) outst_d = outst_d - CntW'(1);

        discard_d = discard_q;
        if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_d - CntW'(1);
        // The stale fetch granted while redirecting is thrown away too.
        if ((state_q == StRedirect) && gnt_hs) discard_d = discard_d + CntW'(1);
        // Everything still in flight after this cycle belongs to the old stream.
        if (flush) discard_d = outst_d;

        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (!push && pop) count_d = count_q - CntW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            addr_q    <= BOOT_ADDR;
            target_q  <= BOOT_ADDR;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            target_q  <= target_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Prefetch data storage; cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) data_mem_q[i] <= '0;
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

`ifdef JEDRO_1_IFU_PC_OUT_EN
    logic [IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IMEM_ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];

    assign instr_pc_o = pc_mem_q[rd_ptr_q];

    // Address of the next response that will be kept; responses are in order.
    always_comb begin
        pc_d = pc_q;
        if (flush)     pc_d = jmp_target;
        else if (push) pc_d = pc_q + IMEM_ADDR_WIDTH'(4);
    end

    // Address storage alongside the data entries.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q <= BOOT_ADDR;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) pc_mem_q[i] <= BOOT_ADDR;
        end else begin
            pc_q <= pc_d;
            if (push) pc_mem_q[wr_ptr_q] <= pc_q;
        end
    end
`endif

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: memory model returns the fetch address as data,
// delivered words are compared against a scoreboard queue of expected instructions.
module tb_jedro_1_ifu;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [DW-1:0] instr_rdata_o;
`ifdef JEDRO_1_IFU_PC_OUT_EN
    logic [AW-1:0] instr_pc_o;
`endif
    logic          instr_next_avail_o;
    logic          instr_next_en_i;
    logic          jmp_instr_i;
    logic [AW-1:0] jmp_address_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [DW-1:0] imem_rdata_i;

    jedro_1_ifu #(
        .DATA_WIDTH      (DW),
        .IMEM_ADDR_WIDTH (AW),
        .BOOT_ADDR       (32'h0000_0000),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .instr_rdata_o      (instr_rdata_o),
`ifdef JEDRO_1_IFU_PC_OUT_EN
        .instr_pc_o         (instr_pc_o),
`endif
        .instr_next_avail_o (instr_next_avail_o),
        .instr_next_en_i    (instr_next_en_i),
        .jmp_instr_i        (jmp_instr_i),
        .jmp_address_i      (jmp_address_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_gnt_i         (imem_gnt_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        gnt_en = 1'b0;
    int          rsp_delay = 1;
    int          pop_budget = 0;
    int          n_gnt = 0;
    int          n_pop = 0;
    logic        ovf_seen = 1'b0;
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] gnt_log [$];
    logic [31:0] exp_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model and decoder-side scoreboard, evaluated mid-cycle.
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (!rstn_i) begin
            pend_addr.delete();
            pend_due.delete();
            imem_gnt_i      = 1'b0;
            imem_rvalid_i   = 1'b0;
            imem_rdata_i    = '0;
            instr_next_en_i = 1'b0;
        end else begin
            imem_gnt_i = gnt_en;
            if (imem_req_o && gnt_en) begin
                pend_addr.push_back(imem_addr_o);
                pend_due.push_back(cyc + rsp_delay);
                gnt_log.push_back(imem_addr_o);
                n_gnt++;
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_addr.pop_front();
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end
            instr_next_en_i = (pop_budget > 0);
            if (instr_next_avail_o && instr_next_en_i && !jmp_instr_i) begin
                checks++;
                n_pop++;
                pop_budget--;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got %h, required no delivery", instr_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_rdata_o !== e) begin
                        errors++;
                        $display("FAIL scoreboard_word: got %h, required %h", instr_rdata_o, e);
                    end
                end
            end
            if (dut.count_q > DEPTH) ovf_seen = 1'b1;
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic hold_reset();
        rstn_i        = 1'b0;
        jmp_instr_i   = 1'b0;
        jmp_address_i = '0;
        gnt_en        = 1'b0;
        pop_budget    = 0;
        rsp_delay     = 1;
        exp_q.delete();
        gnt_log.delete();
        n_gnt = 0;
        n_pop = 0;
        repeat (2) next_cycle();
    endtask

    // Leaves the bench one cycle after release, i.e. in the first REQ cycle.
    task automatic release_reset();
        rstn_i = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (instr_next_avail_o !== 1'b0) begin errors++;
            $display("FAIL reset_avail: got %b, required 0", instr_next_avail_o); end
        checks++; if (instr_rdata_o !== 32'h0) begin errors++;
            $display("FAIL reset_rdata: got %h, required 0", instr_rdata_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b, required 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++;
            $display("FAIL reset_addr: got %h, required 0", imem_addr_o); end
        rstn_i = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++;
            $display("FAIL idle_req: got %b, required 0", imem_req_o); end
        next_cycle();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++;
            $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=0",
                     imem_req_o, imem_addr_o); end
    endtask

    task automatic test_stream();
        hold_reset();
        gnt_en = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        pop_budget = 8;
        release_reset();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++;
            $display("FAIL stream_req0: got req=%b addr=%h, required req=1 addr=0",
                     imem_req_o, imem_addr_o); end
        next_cycle();
        checks++; if (imem_addr_o !== 32'h4 || instr_next_avail_o !== 1'b0) begin errors++;
            $display("FAIL stream_cyc1: got addr=%h avail=%b, required addr=4 avail=0",
                     imem_addr_o, instr_next_avail_o); end
        next_cycle();
        checks++; if (instr_next_avail_o !== 1'b1 || instr_rdata_o !== 32'h0) begin errors++;
            $display("FAIL stream_first_avail: got avail=%b rdata=%h, required avail=1 rdata=0",
                     instr_next_avail_o, instr_rdata_o); end
        repeat (8) next_cycle();
        checks++; if (n_pop !== 8) begin errors++;
            $display("FAIL stream_throughput: got %0d pops, required 8", n_pop); end
        checks++; if (exp_q.size() !== 0) begin errors++;
            $display("FAIL stream_drained: got %0d left, required 0", exp_q.size()); end
        checks++;
        if (gnt_log.size() < 3) begin errors++;
            $display("FAIL stream_addrs: got %0d grants, required at least 3", gnt_log.size());
        end else if (gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 || gnt_log[2] !== 32'h8) begin
            errors++;
            $display("FAIL stream_addrs: got %h %h %h, required 0 4 8",
                     gnt_log[0], gnt_log[1], gnt_log[2]);
        end
    endtask

    task automatic test_fill();
        hold_reset();
        gnt_en = 1'b1;
        exp_q.push_back(32'h0);
        release_reset();
        repeat (10) next_cycle();
        checks++; if (n_gnt !== 4) begin errors++;
            $display("FAIL fill_grants: got %0d, required 4", n_gnt); end
        checks++; if (imem_req_o !== 1'b0) begin errors++;
            $display("FAIL fill_req_off: got %b, required 0", imem_req_o); end
        checks++; if (instr_next_avail_o !== 1'b1 || instr_rdata_o !== 32'h0) begin errors++;
            $display("FAIL fill_head: got avail=%b rdata=%h, required avail=1 rdata=0",
                     instr_next_avail_o, instr_rdata_o); end
        pop_budget = 1;
        repeat (6) next_cycle();
        checks++; if (n_gnt !== 5) begin errors++;
            $display("FAIL fill_regrant: got %0d, required 5", n_gnt); end
        checks++;
        if (gnt_log.size() < 5 || gnt_log[4] !== 32'h10) begin errors++;
            $display("FAIL fill_regrant_addr: got %0d grants, required 5th at 00000010",
                     gnt_log.size()); end
        checks++; if (instr_rdata_o !== 32'h4 || imem_req_o !== 1'b0) begin errors++;
            $display("FAIL fill_second_head: got rdata=%h req=%b, required rdata=4 req=0",
                     instr_rdata_o, imem_req_o); end
    endtask

    task automatic test_jump_drop();
        hold_reset();
        gnt_en    = 1'b1;
        rsp_delay = 4;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        pop_budget = 2;
        release_reset();
        repeat (2) next_cycle();
        jmp_instr_i   = 1'b1;
        jmp_address_i = 32'h100;
        next_cycle();
        jmp_instr_i = 1'b0;
        checks++; if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin errors++;
            $display("FAIL jump_target: got req=%b addr=%h, required req=1 addr=100",
                     imem_req_o, imem_addr_o); end
        checks++; if (instr_next_avail_o !== 1'b0) begin errors++;
            $display("FAIL jump_empty: got %b, required 0", instr_next_avail_o); end
        for (int i = 0; i < 40 && n_pop < 2; i++) next_cycle();
        checks++; if (n_pop !== 2 || exp_q.size() !== 0) begin errors++;
            $display("FAIL jump_delivery: got %0d pops, %0d left, required 2 pops, 0 left",
                     n_pop, exp_q.size()); end
    endtask

    task automatic test_redirect();
        hold_reset();
        gnt_en = 1'b1;
        release_reset();
        repeat (2) next_cycle();
        gnt_en        = 1'b0;
        jmp_instr_i   = 1'b1;
        jmp_address_i = 32'h200;
        next_cycle();
        jmp_instr_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++;
            $display("FAIL redir_hold: got req=%b addr=%h, required req=1 addr=8",
                     imem_req_o, imem_addr_o); end
        checks++; if (instr_next_avail_o !== 1'b0) begin errors++;
            $display("FAIL redir_flush: got %b, required 0", instr_next_avail_o); end
        repeat (3) next_cycle();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++;
            $display("FAIL redir_stable: got req=%b addr=%h, required req=1 addr=8",
                     imem_req_o, imem_addr_o); end
        gnt_en = 1'b1;
        next_cycle();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++;
            $display("FAIL redir_target: got req=%b addr=%h, required req=1 addr=200",
                     imem_req_o, imem_addr_o); end
        exp_q.push_back(32'h200);
        pop_budget = 1;
        for (int i = 0; i < 20 && n_pop < 1; i++) next_cycle();
        checks++; if (n_pop !== 1 || exp_q.size() !== 0) begin errors++;
            $display("FAIL redir_delivery: got %0d pops, %0d left, required 1 pop, 0 left",
                     n_pop, exp_q.size()); end
    endtask

    task automatic test_jump_collision();
        hold_reset();
        gnt_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        pop_budget = 3;
        release_reset();
        repeat (3) next_cycle();
        checks++; if (n_pop !== 1 || instr_next_avail_o !== 1'b1) begin errors++;
            $display("FAIL coll_setup: got pops=%0d avail=%b, required pops=1 avail=1",
                     n_pop, instr_next_avail_o); end
        jmp_instr_i   = 1'b1;
        jmp_address_i = 32'h203;
        next_cycle();
        jmp_instr_i = 1'b0;
        checks++; if (instr_next_avail_o !== 1'b0 || n_pop !== 1) begin errors++;
            $display("FAIL coll_flush: got avail=%b pops=%0d, required avail=0 pops=1",
                     instr_next_avail_o, n_pop); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++;
            $display("FAIL coll_target: got req=%b addr=%h, required req=1 addr=200",
                     imem_req_o, imem_addr_o); end
        for (int i = 0; i < 20 && n_pop < 3; i++) next_cycle();
        checks++; if (n_pop !== 3 || exp_q.size() !== 0) begin errors++;
            $display("FAIL coll_delivery: got %0d pops, %0d left, required 3 pops, 0 left",
                     n_pop, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        gnt_en    = 1'b1;
        rsp_delay = 2;
        release_reset();
        repeat (3) next_cycle();
        checks++; if (n_gnt !== 3 || instr_next_avail_o !== 1'b1 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: got grants=%0d avail=%b req=%b, required 3 1 1",
                     n_gnt, instr_next_avail_o, imem_req_o); end
        rstn_i = 1'b0;
        gnt_en = 1'b0;
        #1;
        checks++; if (instr_next_avail_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++;
            $display("FAIL rstmid_async: got avail=%b req=%b, required 0 0",
                     instr_next_avail_o, imem_req_o); end
        repeat (2) next_cycle();
        gnt_en    = 1'b1;
        rsp_delay = 1;
        exp_q.push_back(32'h0);
        pop_budget = 1;
        release_reset();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++;
            $display("FAIL rstmid_restart: got req=%b addr=%h, required req=1 addr=0",
                     imem_req_o, imem_addr_o); end
        for (int i = 0; i < 20 && n_pop < 1; i++) next_cycle();
        checks++; if (n_pop !== 1 || exp_q.size() !== 0) begin errors++;
            $display("FAIL rstmid_delivery: got %0d pops, required 1", n_pop); end
    endtask

    task automatic test_no_overflow();
        checks++; if (ovf_seen !== 1'b0) begin errors++;
            $display("FAIL fifo_overflow: got occupancy above %0d, required none", DEPTH); end
    endtask

    initial begin
        rstn_i        = 1'b0;
        jmp_instr_i   = 1'b0;
        jmp_address_i = '0;
        test_reset();
        test_stream();
        test_fill();
        test_jump_drop();
        test_redirect();
        test_jump_collision();
        test_reset_mid();
        test_no_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
